// File: rtl/fft_store_pkg.sv
// Shared state type and sizing helpers for the FFT sample/result store.
package fft_store_pkg;

   typedef enum logic [1:0] {
      STORE_LOAD,
      STORE_FEED,
      STORE_COLLECT,
      STORE_DONE
   } store_fsm;

   function automatic logic is_pow2(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

   // Index of the highest set bit; only meaningful for a power of two.
   function automatic int log2(input logic [31:0] v);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++)
         if (v[i]) r = i;
      return r;
   endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Feed count to sample address mapping. Define FFT_BITREV_EN for bit-reversed
// order over log2(N) bits; otherwise samples are fed in natural order.
module fft_bitrev_addr #(
   parameter int ADDR_W = 12,
   parameter int LW     = 4
) (
   input  logic [ADDR_W-1:0] count,
   input  logic [LW-1:0]     log2n,
   output logic [ADDR_W-1:0] addr
);

`ifdef FFT_BITREV_EN
   logic [ADDR_W-1:0] rev;
   logic [LW-1:0]     shamt;

   // Reverse all ADDR_W bits, then drop the unused low bits of a short frame.
   always_comb begin
      rev = '0;
      for (int i = 0; i < ADDR_W; i++)
         rev[i] = count[ADDR_W-1-i];
   end

   assign shamt = LW'(ADDR_W) - log2n;
   assign addr  = rev >> shamt;
`else
   logic unused_log2n;
   assign unused_log2n = ^log2n;
   assign addr         = count;
`endif

endmodule

// File: rtl/fft_sample_store.sv
// Sample buffer, core feeder and result store between the AXI bridge and the
// FFT core. FFT_BITREV_EN selects bit-reversed feed order (see fft_bitrev_addr).
module fft_sample_store
   import fft_store_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096,
   parameter int ADDR_W     = 12
) (
   input  logic                  i_clk,
   input  logic                  i_rstn,
   input  logic [15:0]           i_SAMPLE,
   input  logic [ADDR_W-1:0]     i_SAMPLE_INDEX,
   input  logic                  i_WRITE,
   input  logic                  i_READ,
   input  logic                  i_DATA_LOADED,
   input  logic [ADDR_W:0]       i_SAMPLES_NUMBER,
   output logic [DATA_WIDTH-1:0] o_DATA_TO_BRIDGE,
   output logic                  o_CALC_END,
   output logic [15:0]           o_CORE_SAMPLE,
   output logic                  o_CORE_VALID,
   output logic                  o_CORE_LAST,
   input  logic                  i_CORE_READY,
   input  logic [DATA_WIDTH-1:0] i_CORE_RESULT,
   input  logic                  i_CORE_RESULT_VALID,
   input  logic                  i_CORE_RESULT_LAST,
   output logic                  o_ERR
);

   localparam int              LW      = $clog2(ADDR_W + 1);
   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);

   store_fsm          state;
   logic [ADDR_W-1:0] feed_cnt;
   logic [ADDR_W-1:0] res_cnt;
   logic [ADDR_W-1:0] feed_addr;
   logic [ADDR_W:0]   n_lat;
   logic [ADDR_W:0]   n_last;
   logic [LW-1:0]     log2n;
   logic              res_done;
   logic              n_ok;
   logic              result_fire;
   logic              res_final;
   logic              sample_we;
   logic              unused_read;

   logic [15:0]           sample_mem [DEPTH];
   logic [DATA_WIDTH-1:0] result_mem [DEPTH];

   assign n_last    = n_lat - (ADDR_W + 1)'(1);
   assign n_ok      = is_pow2(32'(i_SAMPLES_NUMBER))
                   && (i_SAMPLES_NUMBER >= (ADDR_W + 1)'(2))
                   && (i_SAMPLES_NUMBER <= DEPTH_N);
   assign sample_we = i_WRITE && ((state == STORE_LOAD) || (state == STORE_DONE));
   // Results may arrive while feeding is still in progress (pipelined cores).
   assign result_fire = i_CORE_RESULT_VALID
                     && ((state == STORE_COLLECT) || ((state == STORE_FEED) && !res_done));
   assign res_final   = ({1'b0, res_cnt} == n_last);
   assign unused_read = i_READ;

   fft_bitrev_addr #(.ADDR_W(ADDR_W), .LW(LW)) u_bitrev (
      .count (feed_cnt),
      .log2n (log2n),
      .addr  (feed_addr)
   );

   // NOTE: the storage arrays are deliberately left out of reset so they map onto RAM.
   always_ff @(posedge i_clk) begin
      if (sample_we)
         sample_mem[i_SAMPLE_INDEX] <= i_SAMPLE;
      if (result_fire)
         result_mem[res_cnt] <= i_CORE_RESULT;
   end

   assign o_CORE_SAMPLE    = sample_mem[feed_addr];
   assign o_DATA_TO_BRIDGE = result_mem[i_SAMPLE_INDEX];

   // NOTE: all state is updated with non-blocking assignments so every branch sees pre-edge values.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state        <= STORE_LOAD;
         feed_cnt     <= '0;
         res_cnt      <= '0;
         n_lat        <= '0;
         log2n        <= '0;
         res_done     <= 1'b0;
         o_CORE_VALID <= 1'b0;
         o_CORE_LAST  <= 1'b0;
         o_CALC_END   <= 1'b0;
         o_ERR        <= 1'b0;
      end else begin
         if (result_fire) begin
            res_cnt <= res_final ? '0 : res_cnt + 1'b1;
            if (i_CORE_RESULT_LAST != res_final)
               o_ERR <= 1'b1;
         end

         unique case (state)
            STORE_LOAD: begin
               if (i_WRITE && i_DATA_LOADED) begin
                  n_lat <= i_SAMPLES_NUMBER;
                  log2n <= LW'(log2(32'(i_SAMPLES_NUMBER)));
                  if (n_ok) begin
                     state        <= STORE_FEED;
                     feed_cnt     <= '0;
                     res_cnt      <= '0;
                     res_done     <= 1'b0;
                     o_CORE_VALID <= 1'b1;
                     o_CORE_LAST  <= 1'b0;
                  end else begin
                     o_ERR <= 1'b1;
                  end
               end
            end

            STORE_FEED: begin
               if (i_WRITE)
                  o_ERR <= 1'b1;
               if (result_fire && res_final)
                  res_done <= 1'b1;
               if (i_CORE_READY) begin
                  if (o_CORE_LAST) begin
                     feed_cnt     <= '0;
                     o_CORE_VALID <= 1'b0;
                     o_CORE_LAST  <= 1'b0;
                     if (res_done || (result_fire && res_final)) begin
                        state      <= STORE_DONE;
                        o_CALC_END <= 1'b1;
                     end else begin
                        state <= STORE_COLLECT;
                     end
                  end else begin
                     feed_cnt    <= feed_cnt + 1'b1;
                     o_CORE_LAST <= (({1'b0, feed_cnt} + (ADDR_W + 1)'(2)) == n_lat);
                  end
               end
            end

            STORE_COLLECT: begin
               if (i_WRITE)
                  o_ERR <= 1'b1;
               if (result_fire && res_final) begin
                  state      <= STORE_DONE;
                  o_CALC_END <= 1'b1;
               end
            end

            STORE_DONE: begin
               if (i_WRITE) begin
                  state      <= STORE_LOAD;
                  o_CALC_END <= 1'b0;
               end
            end

            default: state <= STORE_LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_fft_sample_store.sv
// Scoreboard bench for fft_sample_store; follows FFT_BITREV_EN for the expected feed order.
module tb_fft_sample_store;

   localparam int DW = 32;
   localparam int DP = 4096;
   localparam int AW = 12;

   typedef struct packed {
      logic [15:0] smp;
      logic        last;
   } feed_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   sample = '0;
   logic [AW-1:0] sample_index = '0;
   logic          write = 1'b0;
   logic          read = 1'b0;
   logic          data_loaded = 1'b0;
   logic [AW:0]   samples_number = '0;
   logic [DW-1:0] data_to_bridge;
   logic          calc_end;
   logic [15:0]   core_sample;
   logic          core_valid;
   logic          core_last;
   logic          core_ready = 1'b1;
   logic [DW-1:0] core_result = '0;
   logic          core_result_valid = 1'b0;
   logic          core_result_last = 1'b0;
   logic          err;

   int n_cmp = 0;
   int n_bad = 0;

   feed_t       feed_q [$];
   logic [31:0] res_q [$];
   logic [15:0] model_mem [16];
   logic        hold_v = 1'b0;
   logic [15:0] hold_smp = '0;

   always #5 clk = ~clk;

   fft_sample_store #(.DATA_WIDTH(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
      .i_clk               (clk),
      .i_rstn              (rst_n),
      .i_SAMPLE            (sample),
      .i_SAMPLE_INDEX      (sample_index),
      .i_WRITE             (write),
      .i_READ              (read),
      .i_DATA_LOADED       (data_loaded),
      .i_SAMPLES_NUMBER    (samples_number),
      .o_DATA_TO_BRIDGE    (data_to_bridge),
      .o_CALC_END          (calc_end),
      .o_CORE_SAMPLE       (core_sample),
      .o_CORE_VALID        (core_valid),
      .o_CORE_LAST         (core_last),
      .i_CORE_READY        (core_ready),
      .i_CORE_RESULT       (core_result),
      .i_CORE_RESULT_VALID (core_result_valid),
      .i_CORE_RESULT_LAST  (core_result_last),
      .o_ERR               (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int feed_addr_model(input int c, input int lg);
`ifdef FFT_BITREV_EN
      int r;
      r = 0;
      for (int b = 0; b < lg; b++)
         if (c[b]) r = r | (1 << (lg - 1 - b));
      return r;
`else
      return c + 0 * lg;
`endif
   endfunction

   task automatic pop_feed();
      feed_t f;
      check("feed_q_nonempty", 32'(feed_q.size() != 0), 32'd1);
      if (feed_q.size() != 0) begin
         f = feed_q.pop_front();
         check("feed_sample", 32'(core_sample), 32'(f.smp));
         check("feed_last", 32'(core_last), 32'(f.last));
      end
   endtask

   // Core-side monitor: handshakes pop the scoreboard, stalls must hold data.
   always @(negedge clk) begin
      if (rst_n && core_valid) begin
         if (hold_v)
            check("feed_hold", 32'(core_sample), 32'(hold_smp));
         if (core_ready) begin
            pop_feed();
            hold_v <= 1'b0;
         end else begin
            hold_v   <= 1'b1;
            hold_smp <= core_sample;
         end
      end else begin
         hold_v <= 1'b0;
      end
   end

   task automatic bridge_write(input int idx, input logic [15:0] s, input logic loaded, input int n);
      @(posedge clk); #1;
      write          = 1'b1;
      sample_index   = AW'(idx);
      sample         = s;
      data_loaded    = loaded;
      samples_number = (AW + 1)'(n);
      @(posedge clk); #1;
      write       = 1'b0;
      data_loaded = 1'b0;
   endtask

   // lg = 0 marks a frame the DUT must reject, so nothing is expected on the core port.
   task automatic load_frame(input int n, input int base, input int lg);
      for (int i = 0; i < n; i++)
         model_mem[i] = 16'(base + i);
      if (lg > 0)
         for (int c = 0; c < n; c++)
            feed_q.push_back({model_mem[feed_addr_model(c, lg)], (c == n - 1)});
      for (int i = 0; i < n; i++)
         bridge_write(i, 16'(base + i), (i == n - 1), n);
   endtask

   task automatic wait_feed(input string tag);
      int cyc;
      cyc = 0;
      while (feed_q.size() != 0 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      check(tag, 32'(feed_q.size()), 32'd0);
   endtask

   task automatic drive_results(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         core_result       = DW'(base + i);
         core_result_valid = 1'b1;
         core_result_last  = (i == n - 1);
         res_q.push_back(32'(base + i));
         @(posedge clk); #1;
      end
      core_result_valid = 1'b0;
      core_result_last  = 1'b0;
   endtask

   task automatic read_all(input int n);
      for (int i = 0; i < n; i++) begin
         sample_index = AW'(i);
         read         = 1'b1;
         #1;
         if (res_q.size() != 0)
            check("bridge_read", data_to_bridge, res_q.pop_front());
      end
      read = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      #1;
      check("rst_valid", 32'(core_valid), 32'd0);
      check("rst_last", 32'(core_last), 32'd0);
      check("rst_calc_end", 32'(calc_end), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Frame A: N=8, READY held high, results after the feed completes
      core_ready = 1'b1;
      load_frame(8, 'h10, 3);
      check("a_valid_after_load", 32'(core_valid), 32'd1);
      wait_feed("a_feed_drained");
      check("a_valid_dropped", 32'(core_valid), 32'd0);
      check("a_calc_end_early", 32'(calc_end), 32'd0);
      drive_results(8, 'hA0);
      check("a_calc_end", 32'(calc_end), 32'd1);
      check("a_err", 32'(err), 32'd0);
      sample_index = AW'(5);
      read         = 1'b1;
      #1;
      check("a_read_idx5", data_to_bridge, 32'h0000_00A5);
      read_all(8);

      // Frame B: READY toggled 1,0,0 with results returned while still feeding
      load_frame(8, 'h20, 3);
      check("b_calc_end_cleared", 32'(calc_end), 32'd0);
      fork
         begin
            for (int k = 0; k < 60; k++) begin
               core_ready = (k % 3 == 0);
               @(posedge clk); #1;
            end
            core_ready = 1'b1;
         end
         drive_results(8, 'hB0);
         wait_feed("b_feed_drained");
      join
      check("b_calc_end", 32'(calc_end), 32'd1);
      check("b_err", 32'(err), 32'd0);
      read_all(8);

      // Frame C: N=6 is not a power of two
      load_frame(6, 'h50, 0);
      check("c_err", 32'(err), 32'd1);
      check("c_valid", 32'(core_valid), 32'd0);
      check("c_calc_end", 32'(calc_end), 32'd0);

      // Frame D: stalled feed aborted by reset
      core_ready = 1'b0;
      load_frame(8, 'h30, 3);
      check("d_valid", 32'(core_valid), 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("d_rst_valid", 32'(core_valid), 32'd0);
      check("d_rst_last", 32'(core_last), 32'd0);
      check("d_rst_calc_end", 32'(calc_end), 32'd0);
      check("d_rst_err", 32'(err), 32'd0);
      feed_q.delete();
      @(posedge clk); #1;
      rst_n      = 1'b1;
      core_ready = 1'b1;

      // Frame E: N=4 completes normally after the abort
      load_frame(4, 'h40, 2);
      wait_feed("e_feed_drained");
      check("e_calc_end_early", 32'(calc_end), 32'd0);
      drive_results(4, 'hC0);
      check("e_calc_end", 32'(calc_end), 32'd1);
      check("e_err", 32'(err), 32'd0);
      read_all(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_sample_store.md
# fft_sample_store

Sample/result storage and sequencing stage directly downstream of the AXI bridge in the FFT datapath. Buffers 16-bit samples written by the bridge and, once the bridge flags the frame loaded, streams them (optionally bit-reversed) to the FFT core over a valid/ready port. It captures the core's results into a result memory, raises calc-end, and serves the bridge's burst reads combinationally.

## Interface
- `DATA_WIDTH`, 32: result word width; matches the bridge read-data width.
- `DEPTH`, 4096: sample/result memory depth; power of two.
- `ADDR_W`, 12: index width; equals log2(`DEPTH`).
- `i_clk` in 1: clock, single clock domain.
- `i_rstn` in 1: reset, asynchronous, active-low.
- `i_SAMPLE` in 16: sample from the bridge.
- `i_SAMPLE_INDEX` in `ADDR_W`: bridge write/read index.
- `i_WRITE` in 1: bridge write strobe.
- `i_READ` in 1: bridge read strobe.
- `i_DATA_LOADED` in 1: bridge's last-sample flag, concurrent with the last `i_WRITE`.
- `i_SAMPLES_NUMBER` in `ADDR_W`+1: frame length N.
- `o_DATA_TO_BRIDGE` out `DATA_WIDTH`: `result_mem[i_SAMPLE_INDEX]`, combinational.
- `o_CALC_END` out 1: results complete and readable.
- `o_CORE_SAMPLE` out 16: sample to the FFT core.
- `o_CORE_VALID` out 1: core-sample valid.
- `o_CORE_LAST` out 1: last sample of the frame.
- `i_CORE_READY` in 1: core accepts a sample.
- `i_CORE_RESULT` in `DATA_WIDTH`: result word.
- `i_CORE_RESULT_VALID` in 1: result strobe; no backpressure.
- `i_CORE_RESULT_LAST` in 1: core's last-result flag.
- `o_ERR` out 1: sticky error. Cleared only by reset.

## Operation
- Reset values: FSM in `STORE_LOAD`; `feed_cnt`, `res_cnt` and `n_lat` at 0; `o_CORE_VALID`, `o_CORE_LAST`, `o_CALC_END` and `o_ERR` at 0. Memories are not reset.
- **STORE_LOAD**
  - `i_WRITE` writes `sample_mem[i_SAMPLE_INDEX] <= i_SAMPLE`.
  - On `i_WRITE && i_DATA_LOADED`, latch `n_lat <= i_SAMPLES_NUMBER` and log2(N).
  - If N is a power of two with 2 ≤ N ≤ `DEPTH`, go to `STORE_FEED`. Otherwise set `o_ERR` and stay in `STORE_LOAD`.
  - The final sample is written in that same cycle.
- **STORE_FEED**
  - `o_CORE_VALID=1`; `o_CORE_SAMPLE = sample_mem[feed_addr]`, read asynchronously.
  - `o_CORE_LAST = (feed_cnt == n_lat-1)`.
  - On VALID && READY: `feed_cnt++`.
  - On the last handshake: `feed_cnt <= 0`, go to `STORE_COLLECT`.
  - Data and addressing stay stable while READY is low.
- **STORE_COLLECT**
  - Results are also accepted during `STORE_FEED`, for pipelined cores.
  - Each `i_CORE_RESULT_VALID` writes `result_mem[res_cnt]` and does `res_cnt++`.
  - On the write with `res_cnt == n_lat-1`: `res_cnt <= 0`, go to `STORE_DONE`. If FSM is still in FEED, finish FEED first, then go directly to DONE.
  - `i_CORE_RESULT_LAST` must coincide with that write. A mismatch (early or missing) sets `o_ERR`; the count governs completion regardless.
- **STORE_DONE**
  - `o_CALC_END=1`.
  - The bridge reads via `i_READ`/`i_SAMPLE_INDEX`; `o_DATA_TO_BRIDGE` is valid the same cycle.
  - `i_WRITE` returns the FSM to `STORE_LOAD`, performs that write, and drops `o_CALC_END` next cycle.
- Ignored inputs:
  - `i_WRITE` in FEED or COLLECT is dropped and sets `o_ERR`.
  - `i_READ` outside DONE is harmless and returns stale data.
  - Result strobes in LOAD or DONE are ignored.
- Async reset mid-frame aborts immediately. Memory contents are kept but undefined for use.

## Timing
- LOAD→FEED: first `o_CORE_VALID` one cycle after the `i_DATA_LOADED` write.
- Feed throughput: one sample per cycle while READY is high.
- Last result write → `o_CALC_END` high next cycle.
- Bridge read latency: 0 cycles (combinational), as the bridge requires.

## Configuration
- `FFT_BITREV_EN` defined: `feed_addr` = bit-reverse of `feed_cnt` over log2(N) bits, i.e. reverse(`feed_cnt[ADDR_W-1:0]`) >> (`ADDR_W` − log2N).
- `FFT_BITREV_EN` undefined: `feed_addr = feed_cnt` (natural order). Results are always stored in arrival order.

## Structure
- Package `fft_store_pkg`:
  - enum `store_fsm` {`STORE_LOAD`, `STORE_FEED`, `STORE_COLLECT`, `STORE_DONE`}.
  - `is_pow2`/`log2` helper functions.
- Sub-module `fft_bitrev_addr`: combinational count → address mapping, taking count and log2N. This is where the `FFT_BITREV_EN` switch lives.

## Test plan
- N=8, write samples 0..7 = 0x10..0x17, READY=1, bitrev on → core receives 0x10,14,12,16,11,15,13,17; `o_CORE_LAST` on the 8th sample.
- Same stimulus with bitrev off → core receives 0x10..0x17 in order.
- READY toggled 1,0,0,1… → no sample lost or duplicated; data held stable while READY=0.
- Core returns 8 results 0xA0..0xA7 with LAST on the 8th → `o_CALC_END` next cycle; bridge reads index 5 → 0xA5 same cycle.
- `i_DATA_LOADED` with `i_SAMPLES_NUMBER`=6 → `o_ERR`=1, FSM stays in LOAD, `o_CORE_VALID`=0.
- Reset asserted mid-FEED → all outputs 0 immediately; a new frame of N=4 then completes normally.
